// File: rtl/cpl_enqueue_arbiter.sv
// cpl_enqueue_arbiter
// Lets S_COUNT completion writers share one cpl_queue_manager enqueue port.
// Requests and commits each pass through their own round-robin arbiter and
// one output register. Responses are steered back combinationally using the
// port index that the request path placed in the tag MSBs.
// Optional feature: define CPL_ENQ_ARB_OUTSTANDING_LIMIT_EN to keep a per-port
// count of uncommitted operations. A port holding MAX_OUTSTANDING of them is
// held off the request arbiter until it commits one.

module cpl_enqueue_arbiter #(
    parameter int S_COUNT           = 4,
    parameter int QUEUE_INDEX_WIDTH = 8,
    parameter int QUEUE_PTR_WIDTH   = 16,
    parameter int ADDR_WIDTH        = 64,
    parameter int EVENT_WIDTH       = 8,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int OP_TAG_WIDTH      = 8,
    parameter int MAX_OUTSTANDING   = 4,
    localparam int CL_S             = $clog2(S_COUNT),
    localparam int M_TAG_WIDTH      = REQ_TAG_WIDTH + CL_S
) (
    input  logic                                   clk,
    input  logic                                   rst_n,

    input  logic [S_COUNT*QUEUE_INDEX_WIDTH-1:0]   s_axis_enqueue_req_queue,
    input  logic [S_COUNT*REQ_TAG_WIDTH-1:0]       s_axis_enqueue_req_tag,
    input  logic [S_COUNT-1:0]                     s_axis_enqueue_req_valid,
    output logic [S_COUNT-1:0]                     s_axis_enqueue_req_ready,

    output logic [S_COUNT*QUEUE_INDEX_WIDTH-1:0]   m_axis_enqueue_resp_queue,
    output logic [S_COUNT*QUEUE_PTR_WIDTH-1:0]     m_axis_enqueue_resp_ptr,
    output logic [S_COUNT*ADDR_WIDTH-1:0]          m_axis_enqueue_resp_addr,
    output logic [S_COUNT*EVENT_WIDTH-1:0]         m_axis_enqueue_resp_event,
    output logic [S_COUNT*REQ_TAG_WIDTH-1:0]       m_axis_enqueue_resp_tag,
    output logic [S_COUNT*OP_TAG_WIDTH-1:0]        m_axis_enqueue_resp_op_tag,
    output logic [S_COUNT-1:0]                     m_axis_enqueue_resp_full,
    output logic [S_COUNT-1:0]                     m_axis_enqueue_resp_error,
    output logic [S_COUNT-1:0]                     m_axis_enqueue_resp_valid,
    input  logic [S_COUNT-1:0]                     m_axis_enqueue_resp_ready,

    input  logic [S_COUNT*OP_TAG_WIDTH-1:0]        s_axis_enqueue_commit_op_tag,
    input  logic [S_COUNT-1:0]                     s_axis_enqueue_commit_valid,
    output logic [S_COUNT-1:0]                     s_axis_enqueue_commit_ready,

    output logic [QUEUE_INDEX_WIDTH-1:0]           m_axis_enqueue_req_queue,
    output logic [M_TAG_WIDTH-1:0]                 m_axis_enqueue_req_tag,
    output logic                                   m_axis_enqueue_req_valid,
    input  logic                                   m_axis_enqueue_req_ready,

    input  logic [QUEUE_INDEX_WIDTH-1:0]           s_axis_enqueue_resp_queue,
    input  logic [QUEUE_PTR_WIDTH-1:0]             s_axis_enqueue_resp_ptr,
    input  logic [ADDR_WIDTH-1:0]                  s_axis_enqueue_resp_addr,
    input  logic [EVENT_WIDTH-1:0]                 s_axis_enqueue_resp_event,
    input  logic [M_TAG_WIDTH-1:0]                 s_axis_enqueue_resp_tag,
    input  logic [OP_TAG_WIDTH-1:0]                s_axis_enqueue_resp_op_tag,
    input  logic                                   s_axis_enqueue_resp_full,
    input  logic                                   s_axis_enqueue_resp_error,
    input  logic                                   s_axis_enqueue_resp_valid,
    output logic                                   s_axis_enqueue_resp_ready,

    output logic [OP_TAG_WIDTH-1:0]                m_axis_enqueue_commit_op_tag,
    output logic                                   m_axis_enqueue_commit_valid,
    input  logic                                   m_axis_enqueue_commit_ready
);

    // Returns {found, index} of the first set bit at or after 'start', wrapping.
    function automatic logic [CL_S:0] rr_pick(input logic [S_COUNT-1:0] elig,
                                              input logic [CL_S-1:0] start);
        logic [CL_S:0]   pick;
        logic [CL_S-1:0] idx;
        int              pos;
        pick = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            pos = (int'(start) + k) % S_COUNT;
            idx = pos[CL_S-1:0];
            if (!pick[CL_S] && elig[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    // Port after 'idx', wrapping, so the last winner drops to lowest priority.
    function automatic logic [CL_S-1:0] rr_next(input logic [CL_S-1:0] idx);
        int pos;
        pos = (int'(idx) + 1) % S_COUNT;
        return pos[CL_S-1:0];
    endfunction

    logic [S_COUNT-1:0] req_allow;
    logic [CL_S-1:0]    req_ptr;
    logic [CL_S:0]      req_pick;
    logic [CL_S-1:0]    req_idx;
    logic               req_free;
    logic               req_grant;

    logic [CL_S-1:0]    commit_ptr;
    logic [CL_S:0]      commit_pick;
    logic [CL_S-1:0]    commit_idx;
    logic               commit_free;
    logic               commit_grant;

    logic [CL_S-1:0]    resp_port;
    logic               resp_port_ok;

    // ---------------- request path ----------------
    assign req_free  = !m_axis_enqueue_req_valid || m_axis_enqueue_req_ready;
    assign req_pick  = rr_pick(s_axis_enqueue_req_valid & req_allow, req_ptr);
    assign req_idx   = req_pick[CL_S-1:0];
    assign req_grant = rst_n && req_free && req_pick[CL_S];

    // Exactly the granted port sees ready, and only while the register can load
    always_comb begin
        s_axis_enqueue_req_ready = '0;
        if (req_grant) begin
            s_axis_enqueue_req_ready[req_idx] = 1'b1;
        end
    end

    // Output register toward the manager; tag gains the winning port index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ptr                  <= '0;
            m_axis_enqueue_req_valid <= 1'b0;
            m_axis_enqueue_req_queue <= '0;
            m_axis_enqueue_req_tag   <= '0;
        end else if (req_free) begin
            m_axis_enqueue_req_valid <= req_grant;
            if (req_grant) begin
                m_axis_enqueue_req_queue <= s_axis_enqueue_req_queue[req_idx*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
                m_axis_enqueue_req_tag   <= {req_idx, s_axis_enqueue_req_tag[req_idx*REQ_TAG_WIDTH +: REQ_TAG_WIDTH]};
                req_ptr                  <= rr_next(req_idx);
            end
        end
    end

    // ---------------- commit path ----------------
    assign commit_free  = !m_axis_enqueue_commit_valid || m_axis_enqueue_commit_ready;
    assign commit_pick  = rr_pick(s_axis_enqueue_commit_valid, commit_ptr);
    assign commit_idx   = commit_pick[CL_S-1:0];
    assign commit_grant = rst_n && commit_free && commit_pick[CL_S];

    // Commit ready goes to the commit arbiter's winner only
    always_comb begin
        s_axis_enqueue_commit_ready = '0;
        if (commit_grant) begin
            s_axis_enqueue_commit_ready[commit_idx] = 1'b1;
        end
    end

    // Commit output register, arbitrated independently of requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_ptr                   <= '0;
            m_axis_enqueue_commit_valid  <= 1'b0;
            m_axis_enqueue_commit_op_tag <= '0;
        end else if (commit_free) begin
            m_axis_enqueue_commit_valid <= commit_grant;
            if (commit_grant) begin
                m_axis_enqueue_commit_op_tag <= s_axis_enqueue_commit_op_tag[commit_idx*OP_TAG_WIDTH +: OP_TAG_WIDTH];
                commit_ptr                   <= rr_next(commit_idx);
            end
        end
    end

    // ---------------- response path ----------------
    assign resp_port    = s_axis_enqueue_resp_tag[M_TAG_WIDTH-1 -: CL_S];
    assign resp_port_ok = ({1'b0, resp_port} < (CL_S+1)'(S_COUNT));

    assign m_axis_enqueue_resp_queue  = {S_COUNT{s_axis_enqueue_resp_queue}};
    assign m_axis_enqueue_resp_ptr    = {S_COUNT{s_axis_enqueue_resp_ptr}};
    assign m_axis_enqueue_resp_addr   = {S_COUNT{s_axis_enqueue_resp_addr}};
    assign m_axis_enqueue_resp_event  = {S_COUNT{s_axis_enqueue_resp_event}};
    assign m_axis_enqueue_resp_tag    = {S_COUNT{s_axis_enqueue_resp_tag[REQ_TAG_WIDTH-1:0]}};
    assign m_axis_enqueue_resp_op_tag = {S_COUNT{s_axis_enqueue_resp_op_tag}};
    assign m_axis_enqueue_resp_full   = {S_COUNT{s_axis_enqueue_resp_full}};
    assign m_axis_enqueue_resp_error  = {S_COUNT{s_axis_enqueue_resp_error}};

    // Route valid/ready to the port named in the tag; unknown ports are swallowed
    always_comb begin
        m_axis_enqueue_resp_valid = '0;
        s_axis_enqueue_resp_ready = 1'b0;
        if (rst_n) begin
            if (resp_port_ok) begin
                m_axis_enqueue_resp_valid[resp_port] = s_axis_enqueue_resp_valid;
                s_axis_enqueue_resp_ready            = m_axis_enqueue_resp_ready[resp_port];
            end else begin
                s_axis_enqueue_resp_ready = 1'b1;
            end
        end
    end

    // ---------------- outstanding-op limiter ----------------
`ifdef CPL_ENQ_ARB_OUTSTANDING_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic resp_ok_hs;
    assign resp_ok_hs = s_axis_enqueue_resp_valid && s_axis_enqueue_resp_ready &&
                        !s_axis_enqueue_resp_full && !s_axis_enqueue_resp_error && resp_port_ok;

    for (genvar g = 0; g < S_COUNT; g++) begin : g_limit
        logic [CNT_W-1:0] outstanding;
        logic             inc;
        logic             dec;

        assign inc          = resp_ok_hs && (resp_port == CL_S'(g));
        assign dec          = s_axis_enqueue_commit_valid[g] && s_axis_enqueue_commit_ready[g];
        assign req_allow[g] = (outstanding != CNT_MAX);

        // Ops answered successfully but not yet committed by this port
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                outstanding <= '0;
            end else if (inc && !dec && outstanding != CNT_MAX) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (dec && !inc && outstanding != '0) begin
                outstanding <= outstanding - CNT_W'(1);
            end
        end
    end
`else
    assign req_allow = '1;

    logic unused_max_outstanding;
    assign unused_max_outstanding = (MAX_OUTSTANDING > 0);
`endif

endmodule

// File: tb/tb_cpl_enqueue_arbiter.sv
// tb_cpl_enqueue_arbiter
// Directed scenarios plus randomized traffic, all compared against a
// cycle-level behavioural model of the arbiter kept in this file.
// Honours CPL_ENQ_ARB_OUTSTANDING_LIMIT_EN the same way as the design.

module tb_cpl_enqueue_arbiter;

    localparam int S       = 4;
    localparam int MAX_OUT = 2;

    logic             clk;
    logic             rst_n;
    logic [S*8-1:0]   s_axis_enqueue_req_queue;
    logic [S*8-1:0]   s_axis_enqueue_req_tag;
    logic [S-1:0]     s_axis_enqueue_req_valid;
    logic [S-1:0]     s_axis_enqueue_req_ready;
    logic [S*8-1:0]   m_axis_enqueue_resp_queue;
    logic [S*16-1:0]  m_axis_enqueue_resp_ptr;
    logic [S*64-1:0]  m_axis_enqueue_resp_addr;
    logic [S*8-1:0]   m_axis_enqueue_resp_event;
    logic [S*8-1:0]   m_axis_enqueue_resp_tag;
    logic [S*8-1:0]   m_axis_enqueue_resp_op_tag;
    logic [S-1:0]     m_axis_enqueue_resp_full;
    logic [S-1:0]     m_axis_enqueue_resp_error;
    logic [S-1:0]     m_axis_enqueue_resp_valid;
    logic [S-1:0]     m_axis_enqueue_resp_ready;
    logic [S*8-1:0]   s_axis_enqueue_commit_op_tag;
    logic [S-1:0]     s_axis_enqueue_commit_valid;
    logic [S-1:0]     s_axis_enqueue_commit_ready;
    logic [7:0]       m_axis_enqueue_req_queue;
    logic [9:0]       m_axis_enqueue_req_tag;
    logic             m_axis_enqueue_req_valid;
    logic             m_axis_enqueue_req_ready;
    logic [7:0]       s_axis_enqueue_resp_queue;
    logic [15:0]      s_axis_enqueue_resp_ptr;
    logic [63:0]      s_axis_enqueue_resp_addr;
    logic [7:0]       s_axis_enqueue_resp_event;
    logic [9:0]       s_axis_enqueue_resp_tag;
    logic [7:0]       s_axis_enqueue_resp_op_tag;
    logic             s_axis_enqueue_resp_full;
    logic             s_axis_enqueue_resp_error;
    logic             s_axis_enqueue_resp_valid;
    logic             s_axis_enqueue_resp_ready;
    logic [7:0]       m_axis_enqueue_commit_op_tag;
    logic             m_axis_enqueue_commit_valid;
    logic             m_axis_enqueue_commit_ready;

    cpl_enqueue_arbiter #(
        .S_COUNT(S), .QUEUE_INDEX_WIDTH(8), .QUEUE_PTR_WIDTH(16), .ADDR_WIDTH(64),
        .EVENT_WIDTH(8), .REQ_TAG_WIDTH(8), .OP_TAG_WIDTH(8), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_enqueue_req_queue(s_axis_enqueue_req_queue),
        .s_axis_enqueue_req_tag(s_axis_enqueue_req_tag),
        .s_axis_enqueue_req_valid(s_axis_enqueue_req_valid),
        .s_axis_enqueue_req_ready(s_axis_enqueue_req_ready),
        .m_axis_enqueue_resp_queue(m_axis_enqueue_resp_queue),
        .m_axis_enqueue_resp_ptr(m_axis_enqueue_resp_ptr),
        .m_axis_enqueue_resp_addr(m_axis_enqueue_resp_addr),
        .m_axis_enqueue_resp_event(m_axis_enqueue_resp_event),
        .m_axis_enqueue_resp_tag(m_axis_enqueue_resp_tag),
        .m_axis_enqueue_resp_op_tag(m_axis_enqueue_resp_op_tag),
        .m_axis_enqueue_resp_full(m_axis_enqueue_resp_full),
        .m_axis_enqueue_resp_error(m_axis_enqueue_resp_error),
        .m_axis_enqueue_resp_valid(m_axis_enqueue_resp_valid),
        .m_axis_enqueue_resp_ready(m_axis_enqueue_resp_ready),
        .s_axis_enqueue_commit_op_tag(s_axis_enqueue_commit_op_tag),
        .s_axis_enqueue_commit_valid(s_axis_enqueue_commit_valid),
        .s_axis_enqueue_commit_ready(s_axis_enqueue_commit_ready),
        .m_axis_enqueue_req_queue(m_axis_enqueue_req_queue),
        .m_axis_enqueue_req_tag(m_axis_enqueue_req_tag),
        .m_axis_enqueue_req_valid(m_axis_enqueue_req_valid),
        .m_axis_enqueue_req_ready(m_axis_enqueue_req_ready),
        .s_axis_enqueue_resp_queue(s_axis_enqueue_resp_queue),
        .s_axis_enqueue_resp_ptr(s_axis_enqueue_resp_ptr),
        .s_axis_enqueue_resp_addr(s_axis_enqueue_resp_addr),
        .s_axis_enqueue_resp_event(s_axis_enqueue_resp_event),
        .s_axis_enqueue_resp_tag(s_axis_enqueue_resp_tag),
        .s_axis_enqueue_resp_op_tag(s_axis_enqueue_resp_op_tag),
        .s_axis_enqueue_resp_full(s_axis_enqueue_resp_full),
        .s_axis_enqueue_resp_error(s_axis_enqueue_resp_error),
        .s_axis_enqueue_resp_valid(s_axis_enqueue_resp_valid),
        .s_axis_enqueue_resp_ready(s_axis_enqueue_resp_ready),
        .m_axis_enqueue_commit_op_tag(m_axis_enqueue_commit_op_tag),
        .m_axis_enqueue_commit_valid(m_axis_enqueue_commit_valid),
        .m_axis_enqueue_commit_ready(m_axis_enqueue_commit_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // per-port stimulus, packed onto the DUT buses by applyStimulus
    logic       req_v [S];
    logic [7:0] req_q [S];
    logic [7:0] req_t [S];
    logic       cm_v  [S];
    logic [7:0] cm_t  [S];
    logic       m_req_rdy, m_cm_rdy;
    logic       r_valid, r_full, r_err;
    logic [7:0] r_queue, r_evt, r_op;
    logic [15:0] r_ptr;
    logic [63:0] r_addr;
    logic [9:0] r_tag;
    logic [S-1:0] r_mrdy;

    // behavioural model state
    int         mdl_req_ptr, mdl_cm_ptr;
    bit         mdl_req_v, mdl_cm_v;
    logic [7:0] mdl_req_q, mdl_cm_t;
    logic [9:0] mdl_req_t;
    int         mdl_cnt [S];
    int         last_req_grant, last_cm_grant;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < S; i++) begin
            s_axis_enqueue_req_valid[i]           = req_v[i];
            s_axis_enqueue_req_queue[i*8 +: 8]    = req_q[i];
            s_axis_enqueue_req_tag[i*8 +: 8]      = req_t[i];
            s_axis_enqueue_commit_valid[i]        = cm_v[i];
            s_axis_enqueue_commit_op_tag[i*8 +: 8] = cm_t[i];
        end
        m_axis_enqueue_req_ready    = m_req_rdy;
        m_axis_enqueue_commit_ready = m_cm_rdy;
        s_axis_enqueue_resp_valid   = r_valid;
        s_axis_enqueue_resp_queue   = r_queue;
        s_axis_enqueue_resp_ptr     = r_ptr;
        s_axis_enqueue_resp_addr    = r_addr;
        s_axis_enqueue_resp_event   = r_evt;
        s_axis_enqueue_resp_tag     = r_tag;
        s_axis_enqueue_resp_op_tag  = r_op;
        s_axis_enqueue_resp_full    = r_full;
        s_axis_enqueue_resp_error   = r_err;
        m_axis_enqueue_resp_ready   = r_mrdy;
    endtask

    task automatic clearInputs();
        for (int i = 0; i < S; i++) begin
            req_v[i] = 1'b0; req_q[i] = '0; req_t[i] = '0;
            cm_v[i]  = 1'b0; cm_t[i]  = '0;
        end
        m_req_rdy = 1'b1; m_cm_rdy = 1'b1;
        r_valid = 1'b0; r_full = 1'b0; r_err = 1'b0;
        r_queue = '0; r_evt = '0; r_op = '0; r_ptr = '0; r_addr = '0; r_tag = '0;
        r_mrdy = '1;
    endtask

    task automatic modelReset();
        mdl_req_ptr = 0; mdl_cm_ptr = 0;
        mdl_req_v = 1'b0; mdl_cm_v = 1'b0;
        mdl_req_q = '0; mdl_req_t = '0; mdl_cm_t = '0;
        for (int i = 0; i < S; i++) mdl_cnt[i] = 0;
        last_req_grant = -1; last_cm_grant = -1;
    endtask

    // First eligible port at or after 'start', going round the ring
    function automatic int pickPort(input logic [S-1:0] elig, input int start);
        for (int k = 0; k < S; k++) begin
            automatic int i = (start + k) % S;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit portAllowed(input int i);
`ifdef CPL_ENQ_ARB_OUTSTANDING_LIMIT_EN
        return mdl_cnt[i] < MAX_OUT;
`else
        return (i >= 0);
`endif
    endfunction

    // One clock: drive, compare every output against the model, advance the model
    task automatic stepCycle();
        logic [S-1:0] req_elig, cm_elig, exp_rr, exp_cr, exp_rv;
        int g_req, g_cm, p, q;
        applyStimulus();
        #1;
        checkOutput("m_req_valid", 64'(m_axis_enqueue_req_valid), 64'(mdl_req_v));
        if (mdl_req_v) begin
            checkOutput("m_req_queue", 64'(m_axis_enqueue_req_queue), 64'(mdl_req_q));
            checkOutput("m_req_tag", 64'(m_axis_enqueue_req_tag), 64'(mdl_req_t));
        end
        checkOutput("m_commit_valid", 64'(m_axis_enqueue_commit_valid), 64'(mdl_cm_v));
        if (mdl_cm_v) checkOutput("m_commit_op_tag", 64'(m_axis_enqueue_commit_op_tag), 64'(mdl_cm_t));

        for (int i = 0; i < S; i++) begin
            req_elig[i] = req_v[i] && portAllowed(i);
            cm_elig[i]  = cm_v[i];
        end
        g_req  = (!mdl_req_v || m_req_rdy) ? pickPort(req_elig, mdl_req_ptr) : -1;
        g_cm   = (!mdl_cm_v || m_cm_rdy) ? pickPort(cm_elig, mdl_cm_ptr) : -1;
        exp_rr = (g_req >= 0) ? (S'(1) << g_req) : '0;
        exp_cr = (g_cm >= 0) ? (S'(1) << g_cm) : '0;
        checkOutput("s_req_ready", 64'(s_axis_enqueue_req_ready), 64'(exp_rr));
        checkOutput("s_commit_ready", 64'(s_axis_enqueue_commit_ready), 64'(exp_cr));

        p = int'(r_tag[9:8]);
        q = (p + 1) % S;
        exp_rv = r_valid ? (S'(1) << p) : '0;
        checkOutput("resp_valid", 64'(m_axis_enqueue_resp_valid), 64'(exp_rv));
        checkOutput("s_resp_ready", 64'(s_axis_enqueue_resp_ready), 64'(r_mrdy[p]));
        checkOutput("resp_tag", 64'(m_axis_enqueue_resp_tag[p*8 +: 8]), 64'(r_tag[7:0]));
        checkOutput("resp_queue", 64'(m_axis_enqueue_resp_queue[q*8 +: 8]), 64'(r_queue));
        checkOutput("resp_ptr", 64'(m_axis_enqueue_resp_ptr[q*16 +: 16]), 64'(r_ptr));
        checkOutput("resp_addr", m_axis_enqueue_resp_addr[q*64 +: 64], r_addr);
        checkOutput("resp_event", 64'(m_axis_enqueue_resp_event[q*8 +: 8]), 64'(r_evt));
        checkOutput("resp_op_tag", 64'(m_axis_enqueue_resp_op_tag[p*8 +: 8]), 64'(r_op));
        checkOutput("resp_flags", 64'({m_axis_enqueue_resp_full[q], m_axis_enqueue_resp_error[p]}),
                    64'({r_full, r_err}));

`ifdef CPL_ENQ_ARB_OUTSTANDING_LIMIT_EN
        for (int i = 0; i < S; i++) begin
            automatic int d = 0;
            if (r_valid && r_mrdy[p] && !r_full && !r_err && p == i) d++;
            if (g_cm == i) d--;
            mdl_cnt[i] = mdl_cnt[i] + d;
            if (mdl_cnt[i] < 0) mdl_cnt[i] = 0;
            if (mdl_cnt[i] > MAX_OUT) mdl_cnt[i] = MAX_OUT;
        end
`endif
        if (!mdl_req_v || m_req_rdy) begin
            mdl_req_v = (g_req >= 0);
            if (g_req >= 0) begin
                mdl_req_q   = req_q[g_req];
                mdl_req_t   = 10'(g_req * 256 + int'(req_t[g_req]));
                mdl_req_ptr = (g_req + 1) % S;
            end
        end
        if (!mdl_cm_v || m_cm_rdy) begin
            mdl_cm_v = (g_cm >= 0);
            if (g_cm >= 0) begin
                mdl_cm_t   = cm_t[g_cm];
                mdl_cm_ptr = (g_cm + 1) % S;
            end
        end
        last_req_grant = g_req;
        last_cm_grant  = g_cm;
        @(negedge clk);
    endtask

    // Requesters hold valid and payload until granted, then pick fresh ones
    task automatic randomizeInputs();
        for (int i = 0; i < S; i++) begin
            if (!(req_v[i] && last_req_grant != i)) begin
                req_v[i] = 1'($urandom_range(0, 1));
                req_q[i] = 8'($urandom);
                req_t[i] = 8'($urandom);
            end
            if (!(cm_v[i] && last_cm_grant != i)) begin
                cm_v[i] = 1'($urandom_range(0, 1));
                cm_t[i] = 8'($urandom);
            end
        end
        m_req_rdy = ($urandom_range(0, 3) != 0);
        m_cm_rdy  = ($urandom_range(0, 3) != 0);
        r_valid   = 1'($urandom_range(0, 1));
        r_queue   = 8'($urandom);
        r_ptr     = 16'($urandom);
        r_addr    = {$urandom, $urandom};
        r_evt     = 8'($urandom);
        r_tag     = 10'($urandom);
        r_op      = 8'($urandom);
        r_full    = ($urandom_range(0, 3) == 0);
        r_err     = ($urandom_range(0, 7) == 0);
        r_mrdy    = S'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        clearInputs();
        modelReset();
        for (int i = 0; i < S; i++) req_v[i] = 1'b1;
        cm_v[1] = 1'b1;
        r_valid = 1'b1;
        applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("reset_req_ready", 64'(s_axis_enqueue_req_ready), 64'h0);
        checkOutput("reset_commit_ready", 64'(s_axis_enqueue_commit_ready), 64'h0);
        checkOutput("reset_m_req_valid", 64'(m_axis_enqueue_req_valid), 64'h0);
        checkOutput("reset_m_commit_valid", 64'(m_axis_enqueue_commit_valid), 64'h0);
        checkOutput("reset_resp_valid", 64'(m_axis_enqueue_resp_valid), 64'h0);
        checkOutput("reset_s_resp_ready", 64'(s_axis_enqueue_resp_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clearInputs();

        // ports 0 and 3 commit together: 0x07 first, then 0x09
        cm_v[0] = 1'b1; cm_t[0] = 8'h07;
        cm_v[3] = 1'b1; cm_t[3] = 8'h09;
        stepCycle();
        checkOutput("commit_first", 64'(m_axis_enqueue_commit_op_tag), 64'h07);
        cm_v[0] = 1'b0;
        stepCycle();
        checkOutput("commit_second", 64'(m_axis_enqueue_commit_op_tag), 64'h09);
        checkOutput("commit_second_valid", 64'(m_axis_enqueue_commit_valid), 64'h1);
        cm_v[3] = 1'b0;
        stepCycle();

`ifdef CPL_ENQ_ARB_OUTSTANDING_LIMIT_EN
        // two good responses to port 0 fill its budget; one commit reopens it
        r_valid = 1'b1; r_tag = 10'h011;
        stepCycle();
        stepCycle();
        r_valid = 1'b0;
        req_v[0] = 1'b1; req_q[0] = 8'h33; req_t[0] = 8'h44;
        stepCycle();
        checkOutput("limit_masked", 64'(s_axis_enqueue_req_ready[0]), 64'h0);
        cm_v[0] = 1'b1; cm_t[0] = 8'h55;
        stepCycle();
        cm_v[0] = 1'b0;
        applyStimulus();
        #1;
        checkOutput("limit_reopened", 64'(s_axis_enqueue_req_ready[0]), 64'h1);
        @(negedge clk);
        // the grant above was real; keep the model in step with it
        mdl_req_v = 1'b1; mdl_req_q = 8'h33; mdl_req_t = 10'h044; mdl_req_ptr = 1;
        mdl_cnt[0] = 1;
        req_v[0] = 1'b0;
        stepCycle();
`endif

        // port 2 alone, manager stalls three cycles
        stepCycle();
        req_v[2] = 1'b1; req_q[2] = 8'h05; req_t[2] = 8'hAA;
        stepCycle();
        req_v[2] = 1'b0; m_req_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("stall_valid", 64'(m_axis_enqueue_req_valid), 64'h1);
            checkOutput("stall_queue", 64'(m_axis_enqueue_req_queue), 64'h05);
            checkOutput("stall_tag", 64'(m_axis_enqueue_req_tag), 64'h2AA);
        end
        m_req_rdy = 1'b1;
        stepCycle();
        checkOutput("stall_drained", 64'(m_axis_enqueue_req_valid), 64'h0);

        // response to port 1 while port 1 is not ready
        r_valid = 1'b1; r_tag = 10'h13C; r_mrdy = 4'b1101; r_addr = 64'h1234_5678_9ABC_DEF0;
        stepCycle();
        checkOutput("steer_valid", 64'(m_axis_enqueue_resp_valid), 64'h2);
        checkOutput("steer_tag", 64'(m_axis_enqueue_resp_tag[15:8]), 64'h3C);
        checkOutput("steer_ready_low", 64'(s_axis_enqueue_resp_ready), 64'h0);
        r_mrdy = 4'b1111;
        stepCycle();
        checkOutput("steer_ready_high", 64'(s_axis_enqueue_resp_ready), 64'h1);
        r_valid = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            randomizeInputs();
            stepCycle();
        end

        // reset while the manager-side request is valid
        clearInputs();
        for (int i = 0; i < S; i++) req_v[i] = 1'b1;
        stepCycle();
        checkOutput("pre_reset_valid", 64'(m_axis_enqueue_req_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 64'(m_axis_enqueue_req_valid), 64'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // all ports continuously valid: strict rotation from port 0
        for (int i = 0; i < S; i++) begin
            req_v[i] = 1'b1; req_q[i] = 8'(i); req_t[i] = 8'(16 + i);
        end
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            checkOutput("rotate_tag", 64'(m_axis_enqueue_req_tag), 64'((k % S) * 256 + 16 + (k % S)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
